// File: rtl/trap_sequencer.sv
// Trap controller: accepts one exception or mret, then drives mepc/mcause/mtval/mstatus
// over a shared CSR write port, redirects the PC once and updates the privilege level.
package ExceptStruct;
    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } ExceptPack;
endpackage

module trap_sequencer #(
    parameter logic [1:0] RESET_PRIV = 2'b11,
    parameter bit         WRITE_TVAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  ExceptStruct::ExceptPack except_i,
    input  logic                    mret_i,
    input  logic [63:0]             mstatus_i,
    input  logic [63:0]             mtvec_i,
    input  logic [63:0]             mepc_i,
    output logic                    busy_o,
    output logic                    flush_o,
    output logic                    csr_we_o,
    output logic [11:0]             csr_addr_o,
    output logic [63:0]             csr_wdata_o,
    output logic                    redirect_valid_o,
    output logic [63:0]             redirect_pc_o,
    output logic [1:0]              priv_o
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIR
    } state_t;

    state_t      r_state, w_next;
    logic [63:0] r_epc, r_ecause, r_etval, r_target;
    logic [1:0]  r_prev_priv, r_nextpriv, r_priv;
    logic        r_busy, r_flush, r_we, r_rv;
    logic [11:0] r_addr;
    logic [63:0] r_wdata, r_rpc;

    logic        w_flush, w_we, w_rv, w_latch;
    logic [11:0] w_addr;
    logic [63:0] w_wdata, w_rpc, w_target;
    logic [1:0]  w_nextpriv, w_priv;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- privilege the trap came from.
    function automatic logic [63:0] status_on_trap(input logic [63:0] s, input logic [1:0] pp);
        logic [63:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = pp;
        return r;
    endfunction

    function automatic logic [63:0] status_on_mret(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_flush    = 1'b0;
        w_we       = 1'b0;
        w_addr     = 12'h000;
        w_wdata    = 64'd0;
        w_rv       = 1'b0;
        w_rpc      = 64'd0;
        w_latch    = 1'b0;
        w_target   = r_target;
        w_nextpriv = r_nextpriv;
        w_priv     = r_priv;
        case (r_state)
            IDLE: begin
                if (except_i.except) begin
                    w_next  = W_EPC;
                    w_flush = 1'b1;
                    w_latch = 1'b1;
                end else if (mret_i) begin
                    w_next  = R_STATUS;
                    w_flush = 1'b1;
                end
            end
            W_EPC: begin
                w_we    = 1'b1;
                w_addr  = 12'h341;
                w_wdata = r_epc;
                w_next  = W_CAUSE;
            end
            W_CAUSE: begin
                w_we    = 1'b1;
                w_addr  = 12'h342;
                w_wdata = r_ecause;
                w_next  = WRITE_TVAL ? W_TVAL : W_STATUS;
            end
            W_TVAL: begin
                w_we    = 1'b1;
                w_addr  = 12'h343;
                w_wdata = r_etval;
                w_next  = W_STATUS;
            end
            W_STATUS: begin
                w_we       = 1'b1;
                w_addr     = 12'h300;
                w_wdata    = status_on_trap(mstatus_i, r_prev_priv);
                w_target   = mtvec_i & ~64'h3;
                w_nextpriv = 2'b11;
                w_next     = REDIR;
            end
            R_STATUS: begin
                w_we       = 1'b1;
                w_addr     = 12'h300;
                w_wdata    = status_on_mret(mstatus_i);
                w_target   = mepc_i;
                w_nextpriv = mstatus_i[12:11];
                w_next     = REDIR;
            end
            REDIR: begin
                w_rv   = 1'b1;
                w_rpc  = r_target;
                w_priv = r_nextpriv;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs and the latched exception pack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_epc       <= 64'd0;
            r_ecause    <= 64'd0;
            r_etval     <= 64'd0;
            r_prev_priv <= 2'b00;
            r_target    <= 64'd0;
            r_nextpriv  <= 2'b00;
            r_priv      <= RESET_PRIV;
            r_busy      <= 1'b0;
            r_flush     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 12'h000;
            r_wdata     <= 64'd0;
            r_rv        <= 1'b0;
            r_rpc       <= 64'd0;
        end else begin
            if (w_latch) begin
                r_epc       <= except_i.epc;
                r_ecause    <= except_i.ecause;
                r_etval     <= except_i.etval;
                r_prev_priv <= r_priv;
            end
            r_target   <= w_target;
            r_nextpriv <= w_nextpriv;
            r_priv     <= w_priv;
            r_busy     <= (w_next != IDLE);
            r_flush    <= w_flush;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rv       <= w_rv;
            r_rpc      <= w_rpc;
        end
    end

    assign busy_o           = r_busy;
    assign flush_o          = r_flush;
    assign csr_we_o         = r_we;
    assign csr_addr_o       = r_addr;
    assign csr_wdata_o      = r_wdata;
    assign redirect_valid_o = r_rv;
    assign redirect_pc_o    = r_rpc;
    assign priv_o           = r_priv;

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle trap controller behind the ID-stage exception examiner.
- Accepts one ExceptPack, or an mret request, and flushes the pipeline.
- Sequences the M-mode CSR updates (mepc, mcause, mtval, mstatus) over a single shared CSR write port.
- Updates the current privilege level and issues one PC redirect. Traps always target M-mode; there is no delegation.

Parameters:
- RESET_PRIV, 2'b11: privilege level loaded on reset.
- WRITE_TVAL, 1: 1 = the W_TVAL step is executed; 0 = W_TVAL is skipped and mtval is not written.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- except_i  in  ExceptStruct::ExceptPack  {except, epc[63:0], ecause[63:0], etval[63:0]} from the examiner.
- mret_i  in  1  valid mret in ID.
- mstatus_i  in  64  current mstatus value.
- mtvec_i  in  64  current mtvec value.
- mepc_i  in  64  current mepc value.
- busy_o  out  1  pipeline stall; high in every non-IDLE state.
- flush_o  out  1  one-cycle flush of IF/ID/EX.
- csr_we_o  out  1  CSR write strobe.
- csr_addr_o  out  12  CSR write address.
- csr_wdata_o  out  64  CSR write data.
- redirect_valid_o  out  1  one-cycle PC redirect strobe.
- redirect_pc_o  out  64  redirect target.
- priv_o  out  2  current privilege level, fed to the examiner's priv_i.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; priv_o = RESET_PRIV.
  - All other outputs 0; latched pack cleared.
  - Reset mid-sequence abandons the sequence; no partial CSR write is completed after reset release.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIR.
- Acceptance from IDLE:
  - except_i.except=1: latch epc/ecause/etval and priv_o (as prev_priv); flush_o=1 this cycle; next state = W_EPC.
  - Else mret_i=1: flush_o=1; next state = R_STATUS.
  - except and mret in the same cycle: exception wins, mret is dropped.
- In all non-IDLE states:
  - except_i and mret_i are ignored; no nesting, no queueing.
  - flush_o=0.
- Each W_* / R_STATUS state asserts csr_we_o=1 for exactly one cycle and then advances:
  - W_EPC: addr 0x341, data latched epc -> W_CAUSE.
  - W_CAUSE: addr 0x342, data latched ecause -> W_TVAL if WRITE_TVAL=1, else W_STATUS.
  - W_TVAL: addr 0x343, data latched etval -> W_STATUS.
  - W_STATUS: addr 0x300. Data is mstatus_i with MPIE(bit 7)=MIE(bit 3), MIE=0, MPP(bits 12:11)=prev_priv. -> REDIR with target {mtvec_i[63:2],2'b00}, nextpriv = 2'b11.
  - R_STATUS: addr 0x300. Data is mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b00. -> REDIR with target mepc_i, nextpriv = mstatus_i[12:11].
- mstatus_i, mtvec_i and mepc_i are sampled in the W_STATUS / R_STATUS cycle. Any CSR writes from this block are already visible by then.
- REDIR:
  - redirect_valid_o=1; redirect_pc_o = target; priv_o <= nextpriv at the end of the cycle; csr_we_o=0.
  - Next state = IDLE. busy_o drops in the following cycle.
- Latency:
  - Exception accepted at T: csr_we_o at T+1..T+4 (T+1..T+3 when WRITE_TVAL=0); redirect at T+5 (T+4).
  - mret accepted at T: write at T+1, redirect at T+2.
- Outputs are registered. When not in use, csr_addr_o/csr_wdata_o/redirect_pc_o hold 0 (checked).
- A new request is accepted in the first IDLE cycle after REDIR, giving back-to-back traps.

Test Plan:
- Ecall from U (priv=0, ecause=8, epc=0x8000_0100), mtvec=0x8000_0004, mstatus MIE=1 -> flush at T; writes (0x341,0x80000100), (0x342,8), (0x343,0), (0x300, MPIE=1 MIE=0 MPP=0); redirect 0x8000_0004 at T+5; priv_o=3.
- Illegal instruction 0xFFFF_FFFF, WRITE_TVAL=0 -> mtval never written; redirect at T+4.
- mret with mstatus MPP=1, MPIE=1, mepc=0x8000_0200 -> write 0x300 with MIE=1 MPIE=1 MPP=0; redirect 0x8000_0200 at T+2; priv_o=1.
- except and mret asserted together, then a second except held during busy -> only one trap sequence, exactly one redirect; the second except is accepted only if still present after IDLE returns.
- rstn pulled low during W_CAUSE -> all outputs 0 immediately, priv_o=RESET_PRIV; no further csr_we_o after release.
- Two exceptions back-to-back (second present in the cycle after REDIR) -> second sequence starts immediately, with MPP equal to 3.
